// File: rtl/buzzer_cmd_pkg.sv
// Shared types and default command codes for the buzzer command dispatcher.
package buzzer_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DECODE,
        ST_RUN
    } state_e;

    localparam logic [7:0] CMD_STOP = 8'h1b;
    localparam logic [7:0] CMD_ON   = 8'h44;

endpackage

// File: rtl/buzzer_cmd_decode.sv
// Maps a captured command byte onto a one-hot channel select plus a match flag.
module buzzer_cmd_decode
    import buzzer_cmd_pkg::*;
#(
    parameter int unsigned               DATA_W    = 8,
    parameter int unsigned               N_CMD     = 2,
    parameter logic [N_CMD*DATA_W-1:0]   CMD_CODES = '0
) (
    input  logic [DATA_W-1:0] cmd_byte,
    output logic [N_CMD-1:0]  onehot,
    output logic              match
);

    // Once a slice matches, later (higher) slices are ignored: lowest index wins.
    always_comb begin
        onehot = '0;
        match  = 1'b0;
        for (int unsigned k = 0; k < N_CMD; k++) begin
            if (!match && (cmd_byte == CMD_CODES[k*DATA_W +: DATA_W])) begin
                onehot[k] = 1'b1;
                match     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzzer_cmd_dispatch.sv
// Reads command bytes from a FIFO, decodes them and drives one function channel until done.
// Optional RUN timeout enabled by defining BUZZER_CMD_TIMEOUT_EN.
module buzzer_cmd_dispatch
    import buzzer_cmd_pkg::*;
#(
    parameter int unsigned             DATA_W      = 8,
    parameter int unsigned             N_CMD       = 2,
    parameter logic [N_CMD*DATA_W-1:0] CMD_CODES   = {CMD_ON, CMD_STOP},
    parameter logic [15:0]             TIMEOUT_CYC = 16'd50000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [DATA_W-1:0] FIFO_Read_Data,
    input  logic              Empty_Sig,
    output logic              Read_Req_Sig,
    input  logic [N_CMD-1:0]  Fun_Done_Sig,
    output logic [N_CMD-1:0]  Fun_Start_Sig,
    output logic              Busy_Sig,
    output logic [7:0]        Bad_Cmd_Cnt,
    output logic              Timeout_Sig
);

    if ((N_CMD < 1) || (N_CMD > 8)) begin : g_bad_n_cmd
        $error("N_CMD must be in 1..8");
    end
    if (TIMEOUT_CYC == 16'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..65535");
    end

    state_e              state_q, state_d;
    logic                read_req_q, read_req_d;
    logic [DATA_W-1:0]   cmd_q, cmd_d;
    logic [N_CMD-1:0]    start_q, start_d;
    logic [7:0]          bad_cnt_q, bad_cnt_d;
    logic [N_CMD-1:0]    dec_onehot;
    logic                dec_match;
    logic                done_hit;
    logic                to_expire;

    buzzer_cmd_decode #(
        .DATA_W    (DATA_W),
        .N_CMD     (N_CMD),
        .CMD_CODES (CMD_CODES)
    ) u_decode (
        .cmd_byte (cmd_q),
        .onehot   (dec_onehot),
        .match    (dec_match)
    );

    // start_q is one-hot in RUN, so masking selects only the active channel's done.
    assign done_hit = |(Fun_Done_Sig & start_q);

`ifdef BUZZER_CMD_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    assign to_expire = (to_cnt_q == (TIMEOUT_CYC - 16'd1));

    always_comb begin
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        if (state_q == ST_RUN) begin
            to_cnt_d  = to_cnt_q + 16'd1;
            timeout_d = to_expire && !done_hit;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout_Sig = timeout_q;
`else
    assign to_expire   = 1'b0;
    assign Timeout_Sig = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        read_req_d = 1'b0;
        cmd_d      = cmd_q;
        start_d    = start_q;
        bad_cnt_d  = bad_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!Empty_Sig) begin
                    state_d    = ST_REQ;
                    read_req_d = 1'b1;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                cmd_d   = FIFO_Read_Data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_match) begin
                    state_d = ST_RUN;
                    start_d = dec_onehot;
                end else begin
                    state_d = ST_IDLE;
                    if (bad_cnt_q != 8'hff) begin
                        bad_cnt_d = bad_cnt_q + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (done_hit || to_expire) begin
                    state_d = ST_IDLE;
                    start_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            read_req_q <= 1'b0;
            cmd_q      <= '0;
            start_q    <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            read_req_q <= read_req_d;
            cmd_q      <= cmd_d;
            start_q    <= start_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign Read_Req_Sig  = read_req_q;
    assign Fun_Start_Sig = start_q;
    assign Busy_Sig      = (state_q != ST_IDLE);
    assign Bad_Cmd_Cnt   = bad_cnt_q;

endmodule

// File: tb/tb_buzzer_cmd_dispatch.sv
// Randomized self-checking bench for buzzer_cmd_dispatch with a queue-based FIFO and transaction model.
module tb_buzzer_cmd_dispatch;

    localparam logic [15:0] TO_CYC = 16'd10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic [7:0] rd_data = '0;
    logic       empty   = 1'b1;
    logic       rd_req;
    logic [1:0] done    = '0;
    logic [1:0] start;
    logic       busy;
    logic [7:0] bad_cnt;
    logic       timeout;

    logic [7:0] rd_data4 = '0;
    logic       empty4   = 1'b1;
    logic       rd_req4;
    logic [3:0] done4    = '0;
    logic [3:0] start4;
    logic       busy4;
    logic [7:0] bad4;
    logic       timeout4;

    logic [7:0] fifo_q[$];
    logic [7:0] codes2[2] = '{8'h1b, 8'h44};
    logic [7:0] codes4[4] = '{8'h01, 8'h02, 8'h03, 8'h02};
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         bad_exp   = 0;
    int         bad4_exp  = 0;
    bit         to_window = 1'b0;

    buzzer_cmd_dispatch #(
        .DATA_W      (8),
        .N_CMD       (2),
        .CMD_CODES   ({8'h44, 8'h1b}),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK            (clk),
        .RSTn           (rst_n),
        .FIFO_Read_Data (rd_data),
        .Empty_Sig      (empty),
        .Read_Req_Sig   (rd_req),
        .Fun_Done_Sig   (done),
        .Fun_Start_Sig  (start),
        .Busy_Sig       (busy),
        .Bad_Cmd_Cnt    (bad_cnt),
        .Timeout_Sig    (timeout)
    );

    buzzer_cmd_dispatch #(
        .DATA_W      (8),
        .N_CMD       (4),
        .CMD_CODES   ({8'h02, 8'h03, 8'h02, 8'h01}),
        .TIMEOUT_CYC (TO_CYC)
    ) dut4 (
        .CLK            (clk),
        .RSTn           (rst_n),
        .FIFO_Read_Data (rd_data4),
        .Empty_Sig      (empty4),
        .Read_Req_Sig   (rd_req4),
        .Fun_Done_Sig   (done4),
        .Fun_Start_Sig  (start4),
        .Busy_Sig       (busy4),
        .Bad_Cmd_Cnt    (bad4),
        .Timeout_Sig    (timeout4)
    );

    // FIFO model: data appears one clock after a sampled read request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (rd_req && (fifo_q.size() > 0)) begin
                rd_data <= fifo_q.pop_front();
            end
            empty <= (fifo_q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot2", 32'($onehot0(start)), 32'd1);
            chk("onehot4", 32'($onehot0(start4)), 32'd1);
            chk("timeout4_idle", 32'(timeout4), 32'd0);
            if (!to_window) begin
                chk("timeout_idle", 32'(timeout), 32'd0);
            end
        end
    end

    function automatic int chan2(input logic [7:0] b);
        for (int k = 0; k < 2; k++) if (b == codes2[k]) return k;
        return -1;
    endfunction

    function automatic int chan4(input logic [7:0] b);
        for (int k = 0; k < 4; k++) if (b == codes4[k]) return k;
        return -1;
    endfunction

    task automatic run_cmd(input logic [7:0] b, input int unsigned hold);
        int         k;
        logic [1:0] exp_start;
        k = chan2(b);
        exp_start = (k < 0) ? 2'b00 : 2'(1 << k);
        @(posedge clk); #1;
        fifo_q.push_back(b);
        @(negedge clk);
        @(negedge clk); chk("req_early", 32'(rd_req), 32'd0);
        @(negedge clk); chk("req_rise", 32'(rd_req), 32'd1);
        chk("busy_req", 32'(busy), 32'd1);
        @(negedge clk); chk("req_pulse", 32'(rd_req), 32'd0);
        @(negedge clk); chk("start_early", 32'(start), 32'd0);
        @(negedge clk);
        if (k < 0) begin
            bad_exp = (bad_exp < 255) ? bad_exp + 1 : 255;
            chk("bad_nostart", 32'(start), 32'd0);
            chk("bad_idle", 32'(busy), 32'd0);
            chk("bad_cnt", 32'(bad_cnt), 32'(bad_exp));
        end else begin
            chk("start", 32'(start), 32'(exp_start));
            for (int unsigned i = 0; i < hold; i++) begin
                done = ~exp_start;
                @(negedge clk); chk("start_hold", 32'(start), 32'(exp_start));
            end
            done = exp_start | (2'($urandom) & ~exp_start);
            @(negedge clk);
            chk("start_clear", 32'(start), 32'd0);
            chk("busy_clear", 32'(busy), 32'd0);
            done = '0;
        end
    endtask

    task automatic run_cmd4(input logic [7:0] b);
        int k;
        int n;
        k = chan4(b);
        empty4 = 1'b0;
        n = 0;
        while (!rd_req4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req4_seen", 32'(rd_req4), 32'd1);
        empty4   = 1'b1;
        rd_data4 = b;
        repeat (3) @(negedge clk);
        if (k < 0) begin
            bad4_exp++;
            chk("start4_bad", 32'(start4), 32'd0);
            chk("bad4_cnt", 32'(bad4), 32'(bad4_exp));
        end else begin
            chk("start4", 32'(start4), 32'(1 << k));
            done4 = 4'hf;
            @(negedge clk);
            chk("start4_clear", 32'(start4), 32'd0);
            done4 = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  hi;
        int  pulses;
        bit  saw_start;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(rd_req), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bad", 32'(bad_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); chk("post_rst_req", 32'(rd_req), 32'd0);

        run_cmd(8'h1b, 4);
        run_cmd(8'h44, 3);
        run_cmd(8'h55, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? 8'h1b : (sel == 1) ? 8'h44 : 8'($urandom);
            run_cmd(b, $urandom_range(0, 6));
        end

        // Flood with an unknown code to drive the counter into saturation.
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) fifo_q.push_back(8'h55);
        saw_start = 1'b0;
        n = 0;
        while ((fifo_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            if (start != 0) saw_start = 1'b1;
            n++;
        end
        repeat (6) begin
            @(negedge clk);
            if (start != 0) saw_start = 1'b1;
        end
        chk("flood_drain", 32'(fifo_q.size()), 32'd0);
        chk("flood_nostart", 32'(saw_start), 32'd0);
        chk("flood_bad_sat", 32'(bad_cnt), 32'd255);
        chk("flood_idle", 32'(busy), 32'd0);

`ifdef BUZZER_CMD_TIMEOUT_EN
        to_window = 1'b1;
        @(posedge clk); #1;
        fifo_q.push_back(8'h1b);
        fifo_q.push_back(8'h1b);
        n = 0;
        while (start == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        pulses = 0;
        while (start == 2'b01 && hi < 100) begin
            hi++;
            @(negedge clk);
            if (timeout) pulses++;
        end
        chk("to_start_len", 32'(hi), 32'(TO_CYC));
        n = 0;
        while (start == 0 && n < 20) begin
            @(negedge clk);
            if (timeout) pulses++;
            n++;
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_second_read", 32'(start), 32'd1);
        done = 2'b01;
        @(negedge clk);
        chk("to_second_clear", 32'(start), 32'd0);
        done = '0;
        to_window = 1'b0;
`endif

        // Asynchronous reset while a channel is running.
        @(posedge clk); #1;
        fifo_q.push_back(8'h44);
        n = 0;
        while (start == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_start", 32'(start), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(rd_req), 32'd0);
        chk("arst_bad", 32'(bad_cnt), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        bad_exp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rd_req) saw_start = 1'b1;
        end
        chk("arst_no_read", 32'(saw_start), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);

        bad4_exp = 0;
        run_cmd4(8'h02);
        run_cmd4(8'h03);
        run_cmd4(8'h01);
        run_cmd4(8'h09);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
